registro_controle: RTL

- Command-issuing end of the 2-bit Tx interface: drives opcodes RESET/LOAD/HOLD/SHIFTL to the memory sequencer and consumes its 5-bit `entrada` word.
- Fetches NUM_WORDS consecutive words, shifts each left SHIFT_COUNT times, and presents every result with a one-cycle valid pulse.
- Sits between the top-level start control and the memory block; Tx output wires directly to the memory's Tx input.

---
 rtl/registro_controle_if.sv | 33 +++
 rtl/registro_controle.sv | 110 +++++++++++
 2 files changed

// File: rtl/registro_controle_if.sv
// Command/data bus of registro_controle: start request in, memory word in,
// Tx opcode and result/status out.
interface registro_controle_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic [WIDTH-1:0] entrada;
    logic [1:0]       Tx;
    logic [WIDTH-1:0] saida;
    logic [WIDTH-1:0] etapa;
    logic             out_valid;
    logic             done;

    modport master (
        input  start,
        input  entrada,
        output Tx,
        output saida,
        output etapa,
        output out_valid,
        output done
    );

    modport slave (
        output start,
        output entrada,
        input  Tx,
        input  saida,
        input  etapa,
        input  out_valid,
        input  done
    );
endinterface

// File: rtl/registro_controle.sv
// Issues RESET/LOAD/HOLD/SHIFTL opcodes to the memory sequencer, fetches NUM_WORDS
// words, shifts each left SHIFT_COUNT times and presents them with a valid pulse.
module registro_controle #(
    parameter int WIDTH       = 5,
    parameter int NUM_WORDS   = 3,
    parameter int SHIFT_COUNT = 1
) (
    input logic                 clock,
    input logic                 reset,
    registro_controle_if.master bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_SHIFT = CW'((SHIFT_COUNT > 0) ? SHIFT_COUNT - 1 : 0);
    localparam logic [WIDTH-1:0] LAST_ETAPA = WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        TX_RESET  = 2'b00,
        TX_LOAD   = 2'b01,
        TX_HOLD   = 2'b10,
        TX_SHIFTL = 2'b11
    } tx_e;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        CAPTURE,
        SHIFT,
        EMIT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] saida_q, saida_d;
    logic [WIDTH-1:0] etapa_q, etapa_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            saida_q <= '0;
            etapa_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            saida_q <= saida_d;
            etapa_q <= etapa_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tx/out_valid/done decode from state_q alone so nothing from start or entrada leaks through.
    always_comb begin
        state_d       = state_q;
        saida_d       = saida_q;
        etapa_d       = etapa_q;
        cnt_d         = cnt_q;
        bus.Tx        = TX_HOLD;
        bus.out_valid = 1'b0;
        bus.done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                bus.Tx  = TX_RESET;
                saida_d = '0;
                etapa_d = '0;
                state_d = LOAD;
            end
            LOAD: begin
                bus.Tx  = TX_LOAD;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                saida_d = bus.entrada;
                cnt_d   = '0;
                state_d = (SHIFT_COUNT > 0) ? SHIFT : EMIT;
            end
            SHIFT: begin
                bus.Tx  = TX_SHIFTL;
                saida_d = {saida_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_SHIFT) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                bus.out_valid = 1'b1;
                etapa_d       = etapa_q + 1'b1;
                state_d       = (etapa_q == LAST_ETAPA) ? DONE : LOAD;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.saida = saida_q;
    assign bus.etapa = etapa_q;

endmodule
